eof_ifs_checker: RTL

// - Parametrised end-of-frame checker for the CAN decoder error block; generalises the single-flag EOF check.
// - Checks every bit of EOF plus intermission (IFS) for recessive level, clocked on the bit sample point.
// - Reports a form error with the failing bit position, overload requests, and SOF inside intermission.
// - Sits after the frame decoder (which pulses EOF_Start) and feeds the error/overload frame generator.

---
 rtl/can_pkg.sv | 13 +
 rtl/can_bit_counter.sv | 23 ++
 rtl/eof_ifs_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN decoder definitions: checker state encoding and bus level constants.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EOF  = 2'd1,
    IFS  = 2'd2
  } state_t;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/can_bit_counter.sv
// Bit position counter advanced once per sample point; clr+inc together loads 1.
// Single-cycle update, no backpressure.
module can_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/eof_ifs_checker.sv
// Checks EOF and intermission bits for recessive level, reporting form errors, overloads and early SOF.
// All outputs registered: pulses appear one sample point after the deciding bit; no backpressure.
module eof_ifs_checker
  import can_pkg::*;
#(
  parameter int EOF_LEN   = 7,
  parameter int IFS_LEN   = 3,
  parameter int OVL_LAST  = 1,
  parameter int CHECK_IFS = 1,
  parameter int CW        = $clog2(EOF_LEN + IFS_LEN + 1)
) (
  input  logic          SP,
  input  logic          reset,
  input  logic          RX,
  input  logic          EOF_Start,
  input  logic          Abort,
  output logic          EOF_Error,
  output logic [CW-1:0] Err_Pos,
  output logic          Overload_Req,
  output logic          SOF_Detect,
  output logic          Frame_Done,
  output logic          Busy
);

  localparam logic [CW-1:0] EOF_LAST = CW'(EOF_LEN - 1);
  localparam logic [CW-1:0] IFS_LAST = CW'(IFS_LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr, cnt_inc;
  logic          eof_error_d, overload_d, sof_d, done_d;
  logic [CW-1:0] err_pos_d;

  can_bit_counter #(.W(CW)) u_cnt (
    .clk   (SP),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      EOF_Error    <= 1'b0;
      Overload_Req <= 1'b0;
      SOF_Detect   <= 1'b0;
      Frame_Done   <= 1'b0;
      Err_Pos      <= '0;
    end else begin
      state_q      <= state_d;
      EOF_Error    <= eof_error_d;
      Overload_Req <= overload_d;
      SOF_Detect   <= sof_d;
      Frame_Done   <= done_d;
      Err_Pos      <= err_pos_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    eof_error_d = 1'b0;
    overload_d  = 1'b0;
    sof_d       = 1'b0;
    done_d      = 1'b0;
    err_pos_d   = Err_Pos;

    if (Abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (EOF_Start) begin
      // Start (or restart) always treats this sample as EOF bit 0.
      cnt_clr = 1'b1;
      if (RX == RECESSIVE) begin
        state_d = EOF;
        cnt_inc = 1'b1;
      end else begin
        state_d     = IDLE;
        eof_error_d = 1'b1;
        err_pos_d   = '0;
      end
    end else begin
      case (state_q)
        EOF: begin
          if (RX == RECESSIVE) begin
            if (cnt != EOF_LAST) begin
              cnt_inc = 1'b1;
            end else if (CHECK_IFS != 0) begin
              state_d = IFS;
              cnt_clr = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_clr = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            if (cnt == EOF_LAST && OVL_LAST != 0) begin
              overload_d = 1'b1;
            end else begin
              eof_error_d = 1'b1;
              err_pos_d   = cnt;
            end
          end
        end
        IFS: begin
          if (RX == RECESSIVE) begin
            if (cnt != IFS_LAST) begin
              cnt_inc = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_clr = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            // Dominant in intermission is an overload, or a new SOF on its last bit.
            state_d    = IDLE;
            cnt_clr    = 1'b1;
            overload_d = (cnt != IFS_LAST);
            sof_d      = (cnt == IFS_LAST);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_q != IDLE);

endmodule
